// File: rtl/btb_update_queue.sv
// BTB update queue: buffers mispredicted taken-branch outcomes from execute
// and drains them one per cycle into the BTB write port.
//
// Ports:
//   clk, clkEn, rst        clock, global enable (0 freezes state), sync reset
//   resolve*               resolved-branch report from execute (no backpressure)
//   update, updatePc,
//   updateDest,
//   updateUnconditional    head entry presented to the BTB
//   updateReady            BTB accepts the head entry this cycle
//   count                  number of occupied entries
//   dropCount              saturating count of candidates lost to a full queue
module btb_update_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     clkEn,
    input  logic                     rst,
    input  logic                     resolveValid,
    input  logic [31:0]              resolvePc,
    input  logic [31:0]              resolveDest,
    input  logic                     resolveTaken,
    input  logic                     resolveUnconditional,
    input  logic                     resolveMispredict,
    output logic                     update,
    output logic [31:0]              updatePc,
    output logic [31:0]              updateDest,
    output logic                     updateUnconditional,
    input  logic                     updateReady,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         dropCount
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]      pcq   [DEPTH];
    logic [31:0]      destq [DEPTH];
    logic [DEPTH-1:0] uncq;

    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    youngest;

    logic             cand;
    logic             pop;
    logic             hit;
    logic             canMerge;
    logic             coalesce;
    logic             push;
    logic             drop;
    logic             dropSat;

    assign youngest = tail - PW'(1);

    assign cand = resolveValid & resolveTaken
                & resolveMispredict & clkEn;
    assign pop  = update & updateReady & clkEn;

    // The youngest entry is only mergeable if it is not
    // leaving the queue this cycle; with one entry that
    // entry is also the head.
    assign hit      = (pcq[youngest] == resolvePc);
    assign canMerge = (count >= CW'(2))
                    | ((count == CW'(1)) & ~pop);
    assign coalesce = cand & hit & canMerge;

    // A pop in the same cycle frees a slot on a full queue.
    assign push    = cand & ~coalesce
                   & ((count != CW'(DEPTH)) | pop);
    assign drop    = cand & ~coalesce & ~push;
    assign dropSat = &dropCount;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            dropCount <= '0;
            uncq      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcq[i]   <= '0;
                destq[i] <= '0;
            end
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push) begin
                pcq[tail]   <= resolvePc;
                destq[tail] <= resolveDest;
                uncq[tail]  <= resolveUnconditional;
                tail        <= tail + PW'(1);
            end
            if (coalesce) begin
                destq[youngest] <= resolveDest;
                uncq[youngest]  <= resolveUnconditional;
            end
            count <= count + CW'(push) - CW'(pop);
            if (drop & ~dropSat) begin
                dropCount <= dropCount + CNT_W'(1);
            end
        end
    end

    // Outputs come straight from registered state; no
    // bypass from resolve to update.
    assign update              = (count != '0);
    assign updatePc            = pcq[head];
    assign updateDest          = destq[head];
    assign updateUnconditional = uncq[head];

endmodule

// File: tb/tb_btb_update_queue.sv
// Randomised and directed bench for btb_update_queue with a queue-based
// reference model and a negedge scoreboard monitor.
module tb_btb_update_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int MAXD  = (1 << CNT_W) - 1;

    logic        clk;
    logic        clkEn;
    logic        rst;
    logic        resolveValid;
    logic [31:0] resolvePc;
    logic [31:0] resolveDest;
    logic        resolveTaken;
    logic        resolveUnconditional;
    logic        resolveMispredict;
    logic        update;
    logic [31:0] updatePc;
    logic [31:0] updateDest;
    logic        updateUnconditional;
    logic        updateReady;
    logic [$clog2(DEPTH):0] count;
    logic [CNT_W-1:0]       dropCount;

    btb_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk                  (clk),
        .clkEn                (clkEn),
        .rst                  (rst),
        .resolveValid         (resolveValid),
        .resolvePc            (resolvePc),
        .resolveDest          (resolveDest),
        .resolveTaken         (resolveTaken),
        .resolveUnconditional (resolveUnconditional),
        .resolveMispredict    (resolveMispredict),
        .update               (update),
        .updatePc             (updatePc),
        .updateDest           (updateDest),
        .updateUnconditional  (updateUnconditional),
        .updateReady          (updateReady),
        .count                (count),
        .dropCount            (dropCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] dest;
        logic        unc;
    } ent_t;

    ent_t mq[$];
    int   drops;
    bit   zeroOut;
    bit   started;
    int   errs;
    int   checks;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: compare DUT outputs against the model's
    // current contents, then advance the model using the
    // inputs that the next posedge will sample.
    always @(negedge clk) begin
        bit   pop;
        bit   cand;
        bit   merged;
        int   n;
        ent_t e;
        if (started) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("update", 32'(update), 32'(mq.size() != 0));
            chk("dropCount", 32'(dropCount), 32'(drops));
            if (mq.size() != 0) begin
                chk("head_pc", updatePc, mq[0].pc);
                chk("head_dest", updateDest, mq[0].dest);
                chk("head_unc", 32'(updateUnconditional),
                    32'(mq[0].unc));
            end else if (zeroOut) begin
                chk("rst_pc", updatePc, 32'h0);
                chk("rst_dest", updateDest, 32'h0);
                chk("rst_unc", 32'(updateUnconditional), 32'h0);
            end
        end
        if (rst) begin
            mq.delete();
            drops   = 0;
            zeroOut = 1'b1;
            started = 1'b1;
        end else if (clkEn && started) begin
            n      = mq.size();
            pop    = (n != 0) && updateReady;
            cand   = resolveValid && resolveTaken
                     && resolveMispredict;
            merged = 1'b0;
            if (cand && (n >= 2 || (n == 1 && !pop))
                && mq[n-1].pc == resolvePc) begin
                e      = mq[n-1];
                e.dest = resolveDest;
                e.unc  = resolveUnconditional;
                mq[n-1] = e;
                merged = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (cand && !merged) begin
                if (n < DEPTH || pop) begin
                    e.pc   = resolvePc;
                    e.dest = resolveDest;
                    e.unc  = resolveUnconditional;
                    mq.push_back(e);
                    zeroOut = 1'b0;
                end else if (drops < MAXD) begin
                    drops++;
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc,
                         input logic [31:0] dest, input bit tk,
                         input bit unc, input bit mis,
                         input bit rdy);
        resolveValid         = v;
        resolvePc            = pc;
        resolveDest          = dest;
        resolveTaken         = tk;
        resolveUnconditional = unc;
        resolveMispredict    = mis;
        updateReady          = rdy;
    endtask

    task automatic idle(input bit rdy);
        drive(0, 32'h0, 32'h0, 0, 0, 0, rdy);
    endtask

    task automatic cand(input logic [31:0] pc,
                        input logic [31:0] dest,
                        input bit unc, input bit rdy);
        drive(1, pc, dest, 1, unc, 1, rdy);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errs    = 0;
        checks  = 0;
        drops   = 0;
        started = 0;
        zeroOut = 0;
        clkEn   = 1'b1;
        rst     = 1'b1;
        idle(0);
        cycle();
        cycle();
        rst = 1'b0;
        chk("reset_count", 32'(count), 32'h0);
        chk("reset_update", 32'(update), 32'h0);
        chk("reset_drops", 32'(dropCount), 32'h0);

        // single candidate, immediate drain
        cand(32'h100, 32'h200, 1, 1);
        cycle();
        chk("t1_update", 32'(update), 32'h1);
        chk("t1_pc", updatePc, 32'h100);
        chk("t1_dest", updateDest, 32'h200);
        chk("t1_unc", 32'(updateUnconditional), 32'h1);
        idle(1);
        cycle();
        chk("t1_count_after", 32'(count), 32'h0);

        // filtered resolves never allocate
        drive(1, 32'h110, 32'h220, 0, 0, 1, 1);
        cycle();
        drive(1, 32'h120, 32'h230, 1, 0, 0, 1);
        cycle();
        chk("t2_count", 32'(count), 32'h0);
        chk("t2_update", 32'(update), 32'h0);

        // overflow drops one; drain in order
        for (int i = 0; i < 5; i++) begin
            cand(32'h1000 + 32'(i * 4), 32'h8000 + 32'(i), 0, 0);
            cycle();
        end
        idle(0);
        chk("t3_count_full", 32'(count), 32'h4);
        chk("t3_drops", 32'(dropCount), 32'h1);
        idle(1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_order", updatePc, 32'h1000 + 32'(i * 4));
            cycle();
        end
        chk("t3_empty", 32'(count), 32'h0);

        // back-to-back same PC coalesces
        cand(32'h40, 32'h80, 0, 0);
        cycle();
        cand(32'h40, 32'hC0, 1, 0);
        cycle();
        idle(0);
        chk("t4_count", 32'(count), 32'h1);
        chk("t4_dest", updateDest, 32'hC0);
        chk("t4_unc", 32'(updateUnconditional), 32'h1);

        // full + pop + push in the same cycle
        for (int i = 0; i < 3; i++) begin
            cand(32'h500 + 32'(i * 4), 32'h5000, 0, 0);
            cycle();
        end
        chk("t5_full", 32'(count), 32'h4);
        cand(32'h900, 32'h9000, 0, 1);
        cycle();
        idle(1);
        chk("t5_count", 32'(count), 32'h4);
        chk("t5_drops", 32'(dropCount), 32'h1);
        cycle();
        cycle();
        cycle();
        chk("t5_last", updatePc, 32'h900);
        cycle();
        chk("t5_empty", 32'(count), 32'h0);

        // clock enable freeze, then reset mid-drain
        cand(32'h600, 32'h6000, 0, 0);
        cycle();
        cand(32'h604, 32'h6004, 0, 0);
        cycle();
        clkEn = 1'b0;
        cand(32'h700, 32'h7000, 0, 1);
        cycle();
        chk("t6_frozen_count", 32'(count), 32'h2);
        chk("t6_frozen_pc", updatePc, 32'h600);
        clkEn = 1'b1;
        idle(1);
        cycle();
        chk("t6_popped", 32'(count), 32'h1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_rst_count", 32'(count), 32'h0);
        chk("t6_rst_update", 32'(update), 32'h0);
        cycle();
        chk("t6_after_rst", 32'(update), 32'h0);

        // drop counter saturation
        for (int i = 0; i < DEPTH + MAXD + 45; i++) begin
            cand(32'h3000 + 32'(i * 4), 32'h1, 0, 0);
            cycle();
        end
        idle(0);
        chk("sat_drops", 32'(dropCount), 32'(MAXD));
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // random traffic over a small PC set to hit merges
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 1),
                  32'h2000 + 32'($urandom_range(0, 3) * 4),
                  $urandom,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 2) == 0);
            clkEn = ($urandom_range(0, 9) != 0);
            rst   = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst   = 1'b0;
        clkEn = 1'b1;
        idle(1);
        cycle();
        cycle();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
